// File: rtl/pixel_storer.sv
// Purpose: collects windowed result pixels into a frame buffer and, after end-of-frame, streams the whole frame out in raster order.
// Latency: first Out_Valid one edge after isEnd is taken; then one pixel per cycle while Out_Ready is high.
// Backpressure: Out_Valid && !Out_Ready holds DataOut/Out_Row/Out_Column stable; Enable=0 freezes collection and flush advance.
// Optional: define STORER_THRESHOLD_EN to binarize every output pixel against THRESHOLD.
module pixel_storer #(
  parameter int         WIDTH      = 256,
  parameter int         HEIGHT     = 256,
  parameter logic [7:0] BORDER_VAL = 8'd0,
  parameter int         THRESHOLD  = 128
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [7:0] DataIn,
  input  logic [7:0] In_Row,
  input  logic [7:0] In_Column,
  input  logic       isValid,
  input  logic       isEnd,
  input  logic       Out_Ready,
  output logic [7:0] DataOut,
  output logic [7:0] Out_Row,
  output logic [7:0] Out_Column,
  output logic       Out_Valid,
  output logic       isDone,
  output logic       Error
);

  localparam int          NPIX      = WIDTH * HEIGHT;
  localparam int          AW        = $clog2(NPIX);
  localparam logic [7:0]  ROW_LAST  = 8'(HEIGHT - 1);
  localparam logic [7:0]  COL_LAST  = 8'(WIDTH - 1);
  localparam logic [16:0] EXP_COUNT = 17'((WIDTH - 2) * (HEIGHT - 2));

  // Elaboration-time sanity check on the geometry and threshold range.
  if (WIDTH < 3 || WIDTH > 256 || HEIGHT < 3 || HEIGHT > 256 ||
      THRESHOLD < 0 || THRESHOLD > 255) begin : gBadParams
    $error("pixel_storer: parameter out of range");
  end

  typedef enum logic [1:0] {COLLECT, FLUSH, DONE} storerState_t;

  storerState_t state;
  logic [7:0]   frameBuf [NPIX];
  logic [16:0]  writeCount;

  logic          inRange;
  logic          doWrite;
  logic [AW-1:0] wrAddr;
  logic [7:0]    loadRow;
  logic [7:0]    loadCol;
  logic [AW-1:0] rdAddr;
  logic          loadBorder;
  logic [7:0]    rawVal;
  logic [7:0]    loadVal;
  logic          lastPixel;

  // Only window centres strictly inside the frame are stored.
  assign inRange = (In_Row != 8'd0) && (In_Row < ROW_LAST) &&
                   (In_Column != 8'd0) && (In_Column < COL_LAST);
  assign doWrite = (state == COLLECT) && Enable && isValid && inRange;
  assign wrAddr  = AW'(In_Row * WIDTH + In_Column);

  // Next coordinate to present: pixel 0 when nothing is shown yet, else raster successor.
  always_comb begin
    loadRow = 8'd0;
    loadCol = 8'd0;
    if (Out_Valid) begin
      if (Out_Column == COL_LAST) begin
        loadRow = Out_Row + 8'd1;
        loadCol = 8'd0;
      end else begin
        loadRow = Out_Row;
        loadCol = Out_Column + 8'd1;
      end
    end
  end

  assign rdAddr     = AW'(loadRow * WIDTH + loadCol);
  assign loadBorder = (loadRow == 8'd0) || (loadRow == ROW_LAST) ||
                      (loadCol == 8'd0) || (loadCol == COL_LAST);
  assign rawVal     = loadBorder ? BORDER_VAL : frameBuf[rdAddr];
  assign lastPixel  = (Out_Row == ROW_LAST) && (Out_Column == COL_LAST);

`ifdef STORER_THRESHOLD_EN
  localparam logic [7:0] THR = 8'(THRESHOLD);
  assign loadVal = (rawVal >= THR) ? 8'hFF : 8'h00;
`else
  assign loadVal = rawVal;
`endif

  // Frame buffer write port; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (doWrite) frameBuf[wrAddr] <= DataIn;
  end

  // Collect / flush / done sequencing with registered outputs.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= COLLECT;
      writeCount <= 17'd0;
      DataOut    <= 8'd0;
      Out_Row    <= 8'd0;
      Out_Column <= 8'd0;
      Out_Valid  <= 1'b0;
      isDone     <= 1'b0;
      Error      <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (Enable && isValid) begin
            if (inRange) begin
              if (writeCount != 17'h1FFFF) writeCount <= writeCount + 17'd1;
            end else begin
              Error <= 1'b1;
            end
          end
          if (Enable && isEnd) state <= FLUSH;
        end
        FLUSH: begin
          if (isValid) Error <= 1'b1;
          if (Enable) begin
            if (!Out_Valid || (Out_Ready && !lastPixel)) begin
              Out_Valid  <= 1'b1;
              DataOut    <= loadVal;
              Out_Row    <= loadRow;
              Out_Column <= loadCol;
            end else if (Out_Ready) begin
              Out_Valid <= 1'b0;
              isDone    <= 1'b1;
              state     <= DONE;
              if (writeCount != EXP_COUNT) Error <= 1'b1;
            end
          end
        end
        DONE: begin
          isDone <= 1'b1;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_storer.sv
// Bench for pixel_storer on a 4x4 frame: table-driven collection vectors plus flush sequences.
// Covers reset state, full flush, stalled flush, dropped writes, short frame and reset mid-flush.
// Expected pixels come from a bench-side model of the interior written through the vector table.
module tb_pixel_storer;

  localparam int         W  = 4;
  localparam int         H  = 4;
  localparam logic [7:0] BV = 8'd0;
  localparam int         TH = 25;

  logic       CLK_test;
  logic       Reset, Enable, isValid, isEnd, Out_Ready;
  logic [7:0] DataIn, In_Row, In_Column;
  logic [7:0] DataOut, Out_Row, Out_Column;
  logic       Out_Valid, isDone, Error;

  int nCompared   = 0;
  int nMismatched = 0;

  pixel_storer #(.WIDTH(W), .HEIGHT(H), .BORDER_VAL(BV), .THRESHOLD(TH)) dut (
    .CLK(CLK_test), .Reset(Reset), .Enable(Enable), .DataIn(DataIn),
    .In_Row(In_Row), .In_Column(In_Column), .isValid(isValid), .isEnd(isEnd),
    .Out_Ready(Out_Ready), .DataOut(DataOut), .Out_Row(Out_Row),
    .Out_Column(Out_Column), .Out_Valid(Out_Valid), .isDone(isDone), .Error(Error)
  );

  initial CLK_test = 1'b0;
  always #5 CLK_test = ~CLK_test;

  typedef struct {
    logic       en;
    logic       vld;
    logic [7:0] row;
    logic [7:0] col;
    logic [7:0] data;
    logic       endf;
    logic       expErr;
  } vec_t;

  vec_t       vecs [19];
  logic [7:0] model [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] expPix(input int idx);
    int r, c;
    logic [7:0] v;
    r = idx / W;
    c = idx % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) v = BV;
    else v = model[idx];
`ifdef STORER_THRESHOLD_EN
    v = (v >= 8'(TH)) ? 8'hFF : 8'h00;
`endif
    return v;
  endfunction

  task automatic checkReset(input string tag);
    check($sformatf("%s_vld", tag), Out_Valid, 0);
    check($sformatf("%s_done", tag), isDone, 0);
    check($sformatf("%s_err", tag), Error, 0);
    check($sformatf("%s_dat", tag), DataOut, 0);
    check($sformatf("%s_row", tag), Out_Row, 0);
    check($sformatf("%s_col", tag), Out_Column, 0);
  endtask

  // Asserts Reset at a falling edge, checks the asynchronous clear, releases at the next falling edge.
  task automatic doReset(input string tag);
    Reset = 1'b1;
    Out_Ready = 1'b0;
    #1;
    checkReset(tag);
    @(negedge CLK_test);
    Reset = 1'b0;
  endtask

  task automatic applyRange(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      Enable    = vecs[i].en;
      isValid   = vecs[i].vld;
      In_Row    = vecs[i].row;
      In_Column = vecs[i].col;
      DataIn    = vecs[i].data;
      isEnd     = vecs[i].endf;
      @(negedge CLK_test);
      Enable  = 1'b1;
      isValid = 1'b0;
      isEnd   = 1'b0;
      if (vecs[i].en && vecs[i].vld && vecs[i].row >= 1 && vecs[i].row <= 8'(H - 2) &&
          vecs[i].col >= 1 && vecs[i].col <= 8'(W - 2))
        model[vecs[i].row * W + vecs[i].col] = vecs[i].data;
      check($sformatf("err_vec%0d", i), Error, vecs[i].expErr);
    end
  endtask

  // mode 0: Out_Ready always 1; mode 1: Out_Ready pattern 1,0,0,1 repeating.
  task automatic runFlush(input int mode, input int stopAfter, input logic errMid,
                          input logic errEnd, input string tag);
    int idx = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [7:0] hD = 8'd0, hR = 8'd0, hC = 8'd0;
    logic rdy;
    check($sformatf("%s_lat0", tag), Out_Valid, 0);
    Out_Ready = 1'b0;
    while (idx < stopAfter && cyc < 200) begin
      @(negedge CLK_test);
      cyc++;
      if (cyc == 1) check($sformatf("%s_lat1", tag), Out_Valid, 1);
      if (stalled)
        check($sformatf("%s_hold%0d", tag, idx), {DataOut, Out_Row, Out_Column}, {hD, hR, hC});
      rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      Out_Ready = rdy;
      if (!Out_Valid) begin
        check($sformatf("%s_vld%0d", tag, idx), Out_Valid, 1);
        stalled = 1'b0;
      end else if (rdy) begin
        check($sformatf("%s_pix%0d_dat", tag, idx), DataOut, expPix(idx));
        check($sformatf("%s_pix%0d_row", tag, idx), Out_Row, idx / W);
        check($sformatf("%s_pix%0d_col", tag, idx), Out_Column, idx % W);
        check($sformatf("%s_pix%0d_done", tag, idx), isDone, 0);
        check($sformatf("%s_pix%0d_err", tag, idx), Error, errMid);
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        hD = DataOut;
        hR = Out_Row;
        hC = Out_Column;
      end
    end
    if (idx < stopAfter) check($sformatf("%s_timeout", tag), idx, stopAfter);
    if (stopAfter == W * H) begin
      @(negedge CLK_test);
      Out_Ready = 1'b0;
      check($sformatf("%s_isDone", tag), isDone, 1);
      check($sformatf("%s_vldEnd", tag), Out_Valid, 0);
      check($sformatf("%s_errEnd", tag), Error, errEnd);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    // {en, vld, row, col, data, isEnd, expected Error after the edge}
    vecs[0]  = '{1'b0, 1'b1, 8'd1, 8'd1, 8'd99, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'd1, 8'd1, 8'd10, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 8'd1, 8'd2, 8'd20, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 8'd2, 8'd1, 8'd30, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 8'd2, 8'd2, 8'd40, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 8'd0, 8'd2, 8'd77, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 8'd1, 8'd3, 8'd88, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 8'd0, 8'd0, 8'd0,  1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 8'd1, 8'd1, 8'd11, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 8'd1, 8'd2, 8'd21, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 8'd1, 8'd1, 8'd12, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 8'd1, 8'd1, 8'd5,  1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 8'd1, 8'd2, 8'd6,  1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 8'd2, 8'd1, 8'd7,  1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 8'd2, 8'd2, 8'd8,  1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 8'd2, 8'd2, 8'd50, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 8'd1, 8'd1, 8'd60, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 8'd2, 8'd1, 8'd70, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 8'd1, 8'd2, 8'd80, 1'b1, 1'b0};
    for (int i = 0; i < 16; i++) model[i] = 8'd0;

    Reset = 1'b1; Enable = 1'b1; isValid = 1'b0; isEnd = 1'b0; Out_Ready = 1'b0;
    DataIn = 8'd0; In_Row = 8'd0; In_Column = 8'd0;
    #2;
    checkReset("rst0");
    @(negedge CLK_test);
    Reset = 1'b0;

    // Frame 1: Enable=0 vector ignored, four interior writes, full-rate flush.
    applyRange(0, 4);
    runFlush(0, 16, 1'b0, 1'b0, "f1");

    // Same frame again with Out_Ready toggling 1,0,0,1.
    doReset("rst1");
    applyRange(1, 4);
    runFlush(1, 16, 1'b0, 1'b0, "f2");

    // Out-of-range writes only: dropped, Error immediate, interior unchanged.
    doReset("rst2");
    applyRange(5, 7);
    runFlush(0, 16, 1'b1, 1'b1, "f3");

    // Three interior writes (one repeated coordinate): Error rises with isDone.
    doReset("rst3");
    applyRange(8, 10);
    runFlush(0, 16, 1'b0, 1'b1, "f4");

    // Reset after 7 flushed pixels, then a fresh frame.
    doReset("rst4");
    applyRange(11, 14);
    runFlush(0, 7, 1'b0, 1'b0, "f5");
    @(negedge CLK_test);
    doReset("rstMid");
    applyRange(15, 18);
    runFlush(0, 16, 1'b0, 1'b0, "f6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/pixel_storer.md
Name: pixel_storer

Overview:
- Output-side counterpart of the Loader.
- Collects Sobel result pixels tagged with the window-centre row/column into a full-frame buffer.
- After end-of-frame, streams the frame back out in raster order (row 0 col 0 first) with valid/ready handshake, suitable for dumping to file or a downstream sink.
- Border pixels that the 3x3 window never produces are filled with a constant.

Parameters:
- WIDTH, 256, image width in pixels (2^n not required, 3..256)
- HEIGHT, 256, image height in pixels (3..256)
- BORDER_VAL, 0, 8-bit value emitted for row 0, row HEIGHT-1, col 0, col WIDTH-1
- THRESHOLD, 128, binarization threshold (used only with STORER_THRESHOLD_EN)

Ports:
- CLK  input  1  clock, all state on rising edge
- Reset  input  1  asynchronous, active-high; clears all state
- Enable  input  1  gates collection writes and flush advance
- DataIn  input  8  result pixel for (In_Row, In_Column)
- In_Row  input  8  centre row of the window producing DataIn
- In_Column  input  8  centre column of the window producing DataIn
- isValid  input  1  DataIn/In_Row/In_Column valid this cycle (driven from Loader-side isReady)
- isEnd  input  1  last window of frame; may coincide with final isValid
- Out_Ready  input  1  downstream accepts DataOut this cycle
- DataOut  output  8  flushed pixel
- Out_Row  output  8  row of DataOut
- Out_Column  output  8  column of DataOut
- Out_Valid  output  1  DataOut/Out_Row/Out_Column valid
- isDone  output  1  frame fully flushed
- Error  output  1  sticky fault flag

Behaviour:
- Reset (async): state=COLLECT, write count=0, flush address=0; DataOut=0, Out_Row=0, Out_Column=0, Out_Valid=0, isDone=0, Error=0. Buffer contents not cleared.
- Buffer: WIDTH*HEIGHT x 8 array, address = row*WIDTH+col, asynchronous read, synchronous write.
- COLLECT:
  - Enable&&isValid with 1<=In_Row<=HEIGHT-2 and 1<=In_Column<=WIDTH-2: write DataIn; count+1 (17-bit, saturating).
  - Enable&&isValid with out-of-range coordinate: write dropped, Error<=1.
  - Repeated coordinate: overwrite, counted again.
  - Enable&&isEnd: state<=FLUSH at the same edge; a coincident valid write is performed first.
  - isEnd with Enable=0: ignored.
- FLUSH:
  - First edge in FLUSH (Enable=1): load pixel 0 into the output registers, Out_Valid<=1.
  - Each edge with Out_Valid&&Out_Ready&&Enable: address+1, load next pixel.
  - Out_Valid&&!Out_Ready: DataOut, Out_Row and Out_Column held stable.
  - Enable=0 freezes the advance; an already valid output stays valid.
  - Border coordinates output BORDER_VAL regardless of buffer contents; interior coordinates output buffer contents.
  - Out_Row/Out_Column carry the output pixel's coordinate.
  - isValid during FLUSH: ignored, Error<=1.
  - Acceptance of pixel WIDTH*HEIGHT-1: Out_Valid<=0, isDone<=1, state<=DONE.
  - At the transition to DONE, if count != (WIDTH-2)*(HEIGHT-2): Error<=1.
- DONE: isDone=1 held; all inputs ignored; leave only via Reset.
- Latency: isEnd sampled at edge k -> first Out_Valid at edge k+1 -> throughput 1 pixel/cycle with Out_Ready=1.
- Total flush cycles with Out_Ready=1: WIDTH*HEIGHT.
- Reset mid-FLUSH: outputs return to reset values immediately; the next frame restarts in COLLECT.

Optional Feature:
- Macro STORER_THRESHOLD_EN.
- Defined: every output pixel, including BORDER_VAL, is binarized as DataOut = (value >= THRESHOLD) ? 8'hFF : 8'h00, applied at the output register load; timing unchanged.
- Undefined: DataOut is the raw 8-bit value; THRESHOLD unused.

Test Plan:
- WIDTH=HEIGHT=4, BORDER_VAL=0: write (1,1)=10,(1,2)=20,(2,1)=30,(2,2)=40, isEnd on last write, Out_Ready=1 -> 16 pixels; indices 5,6,9,10 = 10,20,30,40, others 0; isDone after 16th; Error=0.
- Same frame, Out_Ready toggled 1,0,0,1 repeating -> identical sequence, outputs stable while stalled, no pixel lost or duplicated.
- Write (0,2) and (1,3) on 4x4 -> both dropped, Error=1 immediately, buffer interior unchanged.
- Only 3 interior writes then isEnd -> full 16-pixel flush still occurs; Error rises with isDone.
- Reset asserted after 7 flushed pixels -> Out_Valid=0, isDone=0, Error=0 asynchronously; new frame collects and flushes correctly.
- With STORER_THRESHOLD_EN, THRESHOLD=25 on the first frame -> interior outputs 00,00,FF,FF; borders 00.
